// File: rtl/kpn_fire_scheduler.sv
// Static firing scheduler for the KPN pipeline: tracks the five channel FIFO
// occupancies and issues at most one round-robin actor firing per clock.
module kpn_fire_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             src_valid,
  input  logic             sink_ready,
  output logic [3:0]       fire,
  output logic [CNT_W-1:0] occ_0,
  output logic [CNT_W-1:0] occ_1,
  output logic [CNT_W-1:0] occ_2,
  output logic [CNT_W-1:0] occ_3,
  output logic [CNT_W-1:0] occ_4,
  output logic [1:0]       state,
  output logic             done,
  output logic [15:0]      fire_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [3:0]       fire_r;
  logic [CNT_W-1:0] occ_r [5];
  logic [1:0]       ptr_r;
  logic             done_r;
  logic [15:0]      fire_count_r;

  logic [3:0]       elig_s;
  logic             active_s;
  logic             all_zero_s;
  logic             grant_valid_s;
  logic [1:0]       grant_s;
  logic [1:0]       cand_s;

  // Actor eligibility from registered occupancy and state; stop in RUN blocks the source at once.
  always_comb begin
    active_s   = (state_r == RUN) || (state_r == DRAIN);
    all_zero_s = (occ_r[0] == ZERO_C) && (occ_r[1] == ZERO_C) && (occ_r[2] == ZERO_C) &&
                 (occ_r[3] == ZERO_C) && (occ_r[4] == ZERO_C);
    elig_s[0]  = (state_r == RUN) && !stop && src_valid &&
                 (occ_r[0] < FULL_C) && (occ_r[1] < FULL_C);
    elig_s[1]  = active_s && (occ_r[0] != ZERO_C) && (occ_r[1] != ZERO_C) && (occ_r[2] < FULL_C);
    elig_s[2]  = active_s && (occ_r[2] != ZERO_C) && (occ_r[3] < FULL_C) && (occ_r[4] < FULL_C);
    elig_s[3]  = active_s && (occ_r[3] != ZERO_C) && (occ_r[4] != ZERO_C) && sink_ready;
  end

  // Round-robin search starting just after the last granted actor.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = ptr_r;
    cand_s        = ptr_r;
    for (int k = 1; k <= 4; k++) begin
      cand_s = ptr_r + 2'(k);
      if (!grant_valid_s && elig_s[cand_s]) begin
        grant_valid_s = 1'b1;
        grant_s       = cand_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Control FSM, grant registration and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      fire_r       <= 4'b0000;
      ptr_r        <= 2'd3;
      done_r       <= 1'b0;
      fire_count_r <= 16'd0;
      for (int i = 0; i < 5; i++) occ_r[i] <= ZERO_C;
    end else begin
      done_r <= 1'b0;
      fire_r <= 4'b0000;
      case (state_r)
        IDLE:    if (start) state_r <= RUN;
        RUN:     if (stop) state_r <= DRAIN;
        DRAIN: begin
          if (all_zero_s && !grant_valid_s) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (grant_valid_s) begin
        ptr_r          <= grant_s;
        fire_r         <= 4'b0001 << grant_s;
        fire_count_r   <= fire_count_r + 16'd1;
        case (grant_s)
          2'd0: begin
            occ_r[0] <= occ_r[0] + ONE_C;
            occ_r[1] <= occ_r[1] + ONE_C;
          end
          2'd1: begin
            occ_r[0] <= occ_r[0] - ONE_C;
            occ_r[1] <= occ_r[1] - ONE_C;
            occ_r[2] <= occ_r[2] + ONE_C;
          end
          2'd2: begin
            occ_r[2] <= occ_r[2] - ONE_C;
            occ_r[3] <= occ_r[3] + ONE_C;
            occ_r[4] <= occ_r[4] + ONE_C;
          end
          2'd3: begin
            occ_r[3] <= occ_r[3] - ONE_C;
            occ_r[4] <= occ_r[4] - ONE_C;
          end
          default: ptr_r <= grant_s;
        endcase
      end
    end
  end

  assign fire       = fire_r;
  assign occ_0      = occ_r[0];
  assign occ_1      = occ_r[1];
  assign occ_2      = occ_r[2];
  assign occ_3      = occ_r[3];
  assign occ_4      = occ_r[4];
  assign state      = state_r;
  assign done       = done_r;
  assign fire_count = fire_count_r;

endmodule

// File: tb/tb_kpn_fire_scheduler.sv
// Directed bench for kpn_fire_scheduler: a vector table for the steady-flow and
// control sequence, plus hand-written multi-cycle corner-case sequences.
module tb_kpn_fire_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, stop, src_valid, sink_ready;
  logic [3:0]  fire;
  logic [2:0]  occ_0, occ_1, occ_2, occ_3, occ_4;
  logic [1:0]  state;
  logic        done;
  logic [15:0] fire_count;

  int passed = 0;
  int total  = 0;

  kpn_fire_scheduler #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .src_valid(src_valid), .sink_ready(sink_ready), .fire(fire),
    .occ_0(occ_0), .occ_1(occ_1), .occ_2(occ_2), .occ_3(occ_3), .occ_4(occ_4),
    .state(state), .done(done), .fire_count(fire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, sv, sr;
    logic [3:0]  e_fire;
    logic [1:0]  e_state;
    logic [2:0]  e_occ0, e_occ2, e_occ3;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit ok, input string msg);
    total++;
    if (ok) passed++;
    else $display("FAIL %s", msg);
  endtask

  task automatic set_vec(input int i, input logic st, sp, sv, sr, input logic [3:0] f,
                         input logic [1:0] s, input logic [2:0] o0, o2, o3,
                         input logic d, input logic [15:0] c);
    vecs[i] = '{st, sp, sv, sr, f, s, o0, o2, o3, d, c};
  endtask

  int n_fire [4];
  int n_done;
  int guard;
  bit inv_ok, seen, starve_ok;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b0; sink_ready = 1'b0;
    //        i   st sp sv sr fire     state  o0 o2 o3 done cnt
    set_vec(0,  1, 0, 1, 1, 4'b0000, 2'd1, 0, 0, 0, 0, 16'd0);
    set_vec(1,  0, 0, 1, 1, 4'b0001, 2'd1, 1, 0, 0, 0, 16'd1);
    set_vec(2,  0, 0, 1, 1, 4'b0010, 2'd1, 0, 1, 0, 0, 16'd2);
    set_vec(3,  0, 0, 1, 1, 4'b0100, 2'd1, 0, 0, 1, 0, 16'd3);
    set_vec(4,  0, 0, 1, 1, 4'b1000, 2'd1, 0, 0, 0, 0, 16'd4);
    set_vec(5,  0, 0, 1, 1, 4'b0001, 2'd1, 1, 0, 0, 0, 16'd5);
    set_vec(6,  0, 0, 1, 1, 4'b0010, 2'd1, 0, 1, 0, 0, 16'd6);
    set_vec(7,  0, 0, 1, 1, 4'b0100, 2'd1, 0, 0, 1, 0, 16'd7);
    set_vec(8,  0, 0, 1, 1, 4'b1000, 2'd1, 0, 0, 0, 0, 16'd8);
    set_vec(9,  0, 1, 1, 1, 4'b0000, 2'd2, 0, 0, 0, 0, 16'd8);
    set_vec(10, 0, 0, 1, 1, 4'b0000, 2'd0, 0, 0, 0, 1, 16'd8);
    set_vec(11, 0, 0, 1, 1, 4'b0000, 2'd0, 0, 0, 0, 0, 16'd8);
    set_vec(12, 1, 1, 0, 1, 4'b0000, 2'd1, 0, 0, 0, 0, 16'd8);
    set_vec(13, 0, 0, 0, 1, 4'b0000, 2'd1, 0, 0, 0, 0, 16'd8);

    tick(); tick();
    reset = 1'b0;
    chk(state == 2'd0 && fire == 4'd0 && occ_0 == 3'd0 && occ_2 == 3'd0 && fire_count == 16'd0 && !done,
        $sformatf("reset_state state=%0d fire=%b cnt=%0d expected 0/0000/0", state, fire, fire_count));

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].st; stop = vecs[i].sp; src_valid = vecs[i].sv; sink_ready = vecs[i].sr;
      tick();
      chk(fire == vecs[i].e_fire && state == vecs[i].e_state && occ_0 == vecs[i].e_occ0 &&
          occ_1 == vecs[i].e_occ0 && occ_2 == vecs[i].e_occ2 && occ_3 == vecs[i].e_occ3 &&
          occ_4 == vecs[i].e_occ3 && done == vecs[i].e_done && fire_count == vecs[i].e_cnt,
          $sformatf("vec%0d got fire=%b st=%0d occ=%0d%0d%0d%0d%0d done=%b cnt=%0d want fire=%b st=%0d occ0/1=%0d occ2=%0d occ3/4=%0d done=%b cnt=%0d",
                    i, fire, state, occ_0, occ_1, occ_2, occ_3, occ_4, done, fire_count,
                    vecs[i].e_fire, vecs[i].e_state, vecs[i].e_occ0, vecs[i].e_occ2,
                    vecs[i].e_occ3, vecs[i].e_done, vecs[i].e_cnt));
    end

    // Starvation: RUN with no source data for 10 cycles, then data arrives.
    starve_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fire != 4'd0 || occ_0 != 3'd0 || occ_2 != 3'd0 || occ_3 != 3'd0) starve_ok = 1'b0;
    end
    chk(starve_ok, $sformatf("starve_idle fire=%b occ0=%0d expected 0000/0", fire, occ_0));
    src_valid = 1'b1;
    tick();
    chk(fire == 4'b0001 && occ_0 == 3'd1, $sformatf("starve_release fire=%b occ0=%0d expected 0001/1", fire, occ_0));

    // Back-pressure saturation from a clean reset.
    reset = 1'b1; src_valid = 1'b0; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    src_valid = 1'b1; sink_ready = 1'b0;
    n_fire = '{0, 0, 0, 0};
    inv_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      for (int b = 0; b < 4; b++) if (fire[b]) n_fire[b]++;
      if (occ_0 != occ_1 || occ_3 != occ_4 || occ_0 > 3'd4 || occ_2 > 3'd4 || occ_3 > 3'd4) inv_ok = 1'b0;
    end
    chk(n_fire[0] == 12 && n_fire[1] == 8 && n_fire[2] == 4 && n_fire[3] == 0,
        $sformatf("sat_counts src=%0d a1=%0d sp=%0d a2=%0d expected 12/8/4/0", n_fire[0], n_fire[1], n_fire[2], n_fire[3]));
    chk(fire == 4'd0 && occ_0 == 3'd4 && occ_1 == 3'd4 && occ_2 == 3'd4 && occ_3 == 3'd4 && occ_4 == 3'd4 && fire_count == 16'd24,
        $sformatf("sat_final fire=%b occ=%0d%0d%0d%0d%0d cnt=%0d expected 0000/44444/24", fire, occ_0, occ_1, occ_2, occ_3, occ_4, fire_count));
    chk(inv_ok, "sat_invariants occ0==occ1, occ3==occ4, occ<=4 violated");

    // Drain: stop while saturated, then start is ignored, then sink opens.
    stop = 1'b1; tick(); stop = 1'b0;
    chk(state == 2'd2 && fire == 4'd0, $sformatf("drain_enter state=%0d fire=%b expected 2/0000", state, fire));
    start = 1'b1; tick(); start = 1'b0;
    chk(state == 2'd2, $sformatf("drain_start_ignored state=%0d expected 2", state));
    sink_ready = 1'b1;
    n_fire = '{0, 0, 0, 0};
    n_done = 0; inv_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      for (int b = 0; b < 4; b++) if (fire[b]) n_fire[b]++;
      if (done) n_done++;
      if (done && state != 2'd0) inv_ok = 1'b0;
      if (occ_0 != occ_1 || occ_3 != occ_4) inv_ok = 1'b0;
      if (state == 2'd0) seen = 1'b1;
    end
    chk(seen, "drain_timeout state never returned to IDLE");
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) n_done++;
    end
    chk(n_fire[0] == 0 && n_fire[3] == 12,
        $sformatf("drain_counts src=%0d a2=%0d expected 0/12", n_fire[0], n_fire[3]));
    chk(n_done == 1 && inv_ok, $sformatf("drain_done pulses=%0d aligned=%b expected 1/1", n_done, inv_ok));
    chk(state == 2'd0 && occ_0 == 3'd0 && occ_2 == 3'd0 && occ_3 == 3'd0 && fire_count == 16'd48,
        $sformatf("drain_final state=%0d occ=%0d%0d%0d cnt=%0d expected 0/000/48", state, occ_0, occ_2, occ_3, fire_count));

    // Reset held two cycles mid-RUN with occ_2 == 3.
    sink_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (occ_2 != 3'd3 && guard < 50) begin
      tick();
      guard++;
    end
    chk(occ_2 == 3'd3, $sformatf("reset_setup occ2=%0d expected 3", occ_2));
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk(state == 2'd0 && fire == 4'd0 && occ_0 == 3'd0 && occ_1 == 3'd0 && occ_2 == 3'd0 &&
        occ_3 == 3'd0 && occ_4 == 3'd0 && fire_count == 16'd0,
        $sformatf("reset_midrun state=%0d fire=%b occ=%0d%0d%0d%0d%0d cnt=%0d expected all 0",
                  state, fire, occ_0, occ_1, occ_2, occ_3, occ_4, fire_count));

    // fire_count wrap after 65535 firings.
    sink_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (fire_count != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    chk(fire_count == 16'hFFFF, $sformatf("wrap_setup cnt=%0h expected ffff", fire_count));
    tick();
    chk(fire != 4'd0 && fire_count == 16'd0, $sformatf("wrap cnt=%0d fire=%b expected 0 with a firing", fire_count, fire));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
